cp0_exc_ctrl: RTL and testbench

//  Parametrised CP0 with exception/interrupt control. Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14).

---
 rtl/cp0_exc_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file with exception/interrupt prioritisation and a flush/handler/return sequencer.
// Sits beside EXE: serves MTC0/MFC0 and redirects fetch on entry to and return from a handler.
module cp0_exc_ctrl #(
  parameter int          HW_INT     = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_ovf,
  input  logic              exc_ri,
  input  logic              exc_sys,
  input  logic              exc_ades,
  input  logic [31:0]       bad_addr_in,
  input  logic [31:0]       exe_pc,
  input  logic [31:0]       id_pc,
  input  logic [HW_INT-1:0] hw_int,
  input  logic              eret,
  input  logic              mtc0_we,
  input  logic [4:0]        mtc0_addr,
  input  logic [31:0]       mtc0_data,
  input  logic [4:0]        mfc0_addr,
  output logic [31:0]       mfc0_data,
  output logic              if_flush,
  output logic              id_flush,
  output logic              exe_flush,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              in_handler
);

  localparam int              PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(COUNT_DIV - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HANDLER, S_RETURN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       badvaddr_q, badvaddr_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       compare_q, compare_d;
  logic [31:0]       epc_q, epc_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [7:0]        im_q, im_d;
  logic              exl_q, exl_d;
  logic              ie_q, ie_d;
  logic              ti_q, ti_d;
  logic [1:0]        ip_sw_q, ip_sw_d;
  logic [HW_INT-1:0] ip_hw_q, ip_hw_d;
  logic [4:0]        exccode_q, exccode_d;

  logic [7:0]  ip_s;
  logic        int_req_s;
  logic        take_s;
  logic [4:0]  code_s;
  logic [31:0] epc_sel_s;
  logic        bad_we_s;
  logic        mtc0_ok_s;

  // Assemble the visible Cause.IP field and the pending-interrupt request.
  always_comb begin
    ip_s              = 8'h00;
    ip_s[1:0]         = ip_sw_q;
    ip_s[2 +: HW_INT] = ip_hw_q;
    ip_s[7]           = ip_s[7] | ti_q;
    int_req_s         = ie_q & ~exl_q & (|(ip_s & im_q));
  end

  // Pick the highest-priority event; only RUN may accept one. ERET outside a handler is RI.
  always_comb begin
    take_s    = 1'b0;
    code_s    = EXC_INT;
    epc_sel_s = exe_pc;
    bad_we_s  = 1'b0;
    if (state_q == S_RUN) begin
      if (int_req_s) begin
        take_s = 1'b1;
      end else if (exc_ovf) begin
        take_s = 1'b1;
        code_s = EXC_OV;
      end else if (exc_ades) begin
        take_s   = 1'b1;
        code_s   = EXC_ADES;
        bad_we_s = 1'b1;
      end else if (eret && !exl_q) begin
        take_s = 1'b1;
        code_s = EXC_RI;
      end else if (exc_ri) begin
        take_s    = 1'b1;
        code_s    = EXC_RI;
        epc_sel_s = id_pc;
      end else if (exc_sys) begin
        take_s    = 1'b1;
        code_s    = EXC_SYS;
        epc_sel_s = id_pc;
      end else begin
        take_s = 1'b0;
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:     state_d = take_s ? S_FLUSH : S_RUN;
      S_FLUSH:   state_d = S_HANDLER;
      S_HANDLER: state_d = eret ? S_RETURN : S_HANDLER;
      S_RETURN:  state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  // Sequencer outputs are decoded from the registered state only.
  always_comb begin
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    exe_flush   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    case (state_q)
      S_FLUSH: begin
        if_flush    = 1'b1;
        id_flush    = 1'b1;
        exe_flush   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = EXC_VECTOR;
      end
      S_RETURN: begin
        if_flush    = 1'b1;
        id_flush    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_q;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

  // Register file updates: software writes first, then the event capture and ERET override them.
  always_comb begin
    mtc0_ok_s  = mtc0_we & ~take_s;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    ip_hw_d    = hw_int;

    if (mtc0_ok_s && mtc0_addr == REG_COUNT) begin
      count_d = mtc0_data;
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      count_d = count_q + 32'd1;
      presc_d = '0;
    end else begin
      count_d = count_q;
      presc_d = presc_q + PW'(1);
    end

    // A Compare write both retargets the timer and acknowledges it.
    if (mtc0_ok_s && mtc0_addr == REG_COMPARE) begin
      compare_d = mtc0_data;
      ti_d      = 1'b0;
    end else if (count_q == compare_q && compare_q != 32'd0) begin
      ti_d = 1'b1;
    end else begin
      ti_d = ti_q;
    end

    if (mtc0_ok_s) begin
      case (mtc0_addr)
        REG_STATUS: begin
          im_d  = mtc0_data[15:8];
          exl_d = mtc0_data[1];
          ie_d  = mtc0_data[0];
        end
        REG_CAUSE: ip_sw_d = mtc0_data[9:8];
        REG_EPC:   epc_d   = mtc0_data;
        default:   ip_sw_d = ip_sw_q;
      endcase
    end else begin
      ip_sw_d = ip_sw_q;
    end

    if (take_s) begin
      epc_d     = epc_sel_s;
      exccode_d = code_s;
      exl_d     = 1'b1;
      if (bad_we_s) begin
        badvaddr_d = bad_addr_in;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else if (state_q == S_HANDLER && eret) begin
      exl_d = 1'b0;
    end else begin
      exccode_d = exccode_q;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // CP0 architectural registers and the Count prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= 32'h0000_0000;
      count_q    <= 32'h0000_0000;
      compare_q  <= 32'h0000_0000;
      epc_q      <= 32'h0000_0000;
      presc_q    <= '0;
      im_q       <= 8'h00;
      exl_q      <= 1'b1;
      ie_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      ip_hw_q    <= '0;
      exccode_q  <= 5'h00;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      presc_q    <= presc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exccode_q  <= exccode_d;
    end
  end

  // MFC0 read mux; unimplemented numbers read as zero.
  always_comb begin
    case (mfc0_addr)
      REG_BADVADDR: mfc0_data = badvaddr_q;
      REG_COUNT:    mfc0_data = count_q;
      REG_COMPARE:  mfc0_data = compare_q;
      REG_STATUS:   mfc0_data = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
      REG_CAUSE:    mfc0_data = {1'b0, ti_q, 14'h0000, ip_s, 1'b0, exccode_q, 2'b00};
      REG_EPC:      mfc0_data = epc_q;
      default:      mfc0_data = 32'h0000_0000;
    endcase
  end

  assign in_handler = exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expectations (HW_INT=6, COUNT_DIV=2).
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_ovf, exc_ri, exc_sys, exc_ades;
  logic [31:0] bad_addr_in, exe_pc, id_pc;
  logic [5:0]  hw_int;
  logic        eret, mtc0_we;
  logic [4:0]  mtc0_addr, mfc0_addr;
  logic [31:0] mtc0_data, mfc0_data;
  logic        if_flush, id_flush, exe_flush, redirect, in_handler;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  cp0_exc_ctrl #(.HW_INT(6), .COUNT_DIV(2), .EXC_VECTOR(32'hBFC0_0380)) dut (
    .clk(clk), .reset(reset),
    .exc_ovf(exc_ovf), .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_ades(exc_ades),
    .bad_addr_in(bad_addr_in), .exe_pc(exe_pc), .id_pc(id_pc), .hw_int(hw_int),
    .eret(eret), .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
    .if_flush(if_flush), .id_flush(id_flush), .exe_flush(exe_flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cp0_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    mfc0_addr = addr;
    #1;
    check(tag, mfc0_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    mtc0_we   = 1'b1;
    mtc0_addr = addr;
    mtc0_data = data;
    tick();
    mtc0_we   = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [2:0] flush, input logic redir,
                           input logic [31:0] pc);
    check({tag, "_flush"}, {29'd0, if_flush, id_flush, exe_flush}, {29'd0, flush});
    check({tag, "_redir"}, {31'd0, redirect}, {31'd0, redir});
    if (redir) check({tag, "_pc"}, redirect_pc, pc);
  endtask

  initial begin
    reset = 1'b1; exc_ovf = 1'b0; exc_ri = 1'b0; exc_sys = 1'b0; exc_ades = 1'b0;
    bad_addr_in = 32'd0; exe_pc = 32'd0; id_pc = 32'd0; hw_int = 6'd0; eret = 1'b0;
    mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_data = 32'd0; mfc0_addr = 5'd0;
    tick(); tick();

    // Reset state
    check_seq("rst", 3'b000, 1'b0, 32'd0);
    check("rst_inh", {31'd0, in_handler}, 32'd1);
    cp0_check("rst_status", 5'd12, 32'h0000_0002);
    cp0_check("rst_cause", 5'd13, 32'h0000_0000);
    cp0_check("rst_count", 5'd9, 32'h0000_0000);
    reset = 1'b0;

    // Ov and RI together: Ov wins, EPC from EXE
    mtc0(5'd12, 32'h0000_0001);
    check("t1_inh", {31'd0, in_handler}, 32'd0);
    exc_ovf = 1'b1; exc_ri = 1'b1; exe_pc = 32'h80; id_pc = 32'h84;
    tick();
    exc_ovf = 1'b0; exc_ri = 1'b0;
    check_seq("t1", 3'b111, 1'b1, 32'hBFC0_0380);
    cp0_check("t1_epc", 5'd14, 32'h80);
    cp0_check("t1_cause", 5'd13, 32'h30);
    check("t1_inh2", {31'd0, in_handler}, 32'd1);
    tick();
    check_seq("t1_hdl", 3'b000, 1'b0, 32'd0);

    // No nesting inside the handler
    exc_ri = 1'b1;
    tick();
    exc_ri = 1'b0;
    check_seq("t2_nonest", 3'b000, 1'b0, 32'd0);
    cp0_check("t2_cause", 5'd13, 32'h30);

    // EPC rewritten in handler, ERET returns there
    mtc0(5'd14, 32'h200);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_seq("t3_ret", 3'b110, 1'b1, 32'h200);
    check("t3_inh", {31'd0, in_handler}, 32'd0);
    tick();
    check_seq("t3_run", 3'b000, 1'b0, 32'd0);

    // Syscall with a coincident MTC0 EPC: the write is dropped
    exc_sys = 1'b1; id_pc = 32'h90;
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h555;
    tick();
    exc_sys = 1'b0; mtc0_we = 1'b0;
    cp0_check("sys_epc", 5'd14, 32'h90);
    cp0_check("sys_cause", 5'd13, 32'h20);
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_seq("sys_ret", 3'b110, 1'b1, 32'h90);
    tick();

    // Count wrap and MTC0 Count beating a coincident increment
    mtc0(5'd9, 32'hFFFF_FFFF);
    cp0_check("t5_cnt0", 5'd9, 32'hFFFF_FFFF);
    tick();
    cp0_check("t5_cnt1", 5'd9, 32'hFFFF_FFFF);
    tick();
    cp0_check("t5_wrap", 5'd9, 32'h0000_0000);
    tick();
    mtc0(5'd9, 32'h1234);
    cp0_check("t5_hold", 5'd9, 32'h1234);
    tick();
    cp0_check("t5_hold2", 5'd9, 32'h1234);

    // Timer interrupt
    exe_pc = 32'h100;
    mtc0(5'd11, 32'd10);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    repeat (19) tick();
    cp0_check("t4_cnt9", 5'd9, 32'd9);
    tick();
    cp0_check("t4_cnt10", 5'd9, 32'd10);
    cp0_check("t4_noti", 5'd13, 32'h0000_0020);
    tick();
    cp0_check("t4_ti", 5'd13, 32'h4000_8020);
    check("t4_noredir", {31'd0, redirect}, 32'd0);
    tick();
    check_seq("t4_int", 3'b111, 1'b1, 32'hBFC0_0380);
    cp0_check("t4_cause", 5'd13, 32'h4000_8000);
    cp0_check("t4_epc", 5'd14, 32'h100);
    tick();
    mtc0(5'd11, 32'd0);
    cp0_check("t4_ticlr", 5'd13, 32'h0000_0000);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_seq("t4_ret", 3'b110, 1'b1, 32'h100);
    tick();

    // Hardware line 0 lands on Cause bit 10 one cycle later; unimplemented reads zero
    hw_int = 6'b000001;
    tick();
    hw_int = 6'b000000;
    cp0_check("hw_ip", 5'd13, 32'h0000_0400);
    cp0_check("unimpl", 5'd5, 32'h0000_0000);
    tick();

    // AdES captures BadVAddr; reset during FLUSH aborts the sequence
    exc_ades = 1'b1; bad_addr_in = 32'h1003; exe_pc = 32'h104;
    tick();
    exc_ades = 1'b0;
    cp0_check("t6_bad", 5'd8, 32'h1003);
    cp0_check("t6_cause", 5'd13, 32'h14);
    check("t6_redir", {31'd0, redirect}, 32'd1);
    reset = 1'b1;
    tick();
    check_seq("t6_rst", 3'b000, 1'b0, 32'd0);
    check("t6_inh", {31'd0, in_handler}, 32'd1);
    cp0_check("t6_status", 5'd12, 32'h0000_0002);
    cp0_check("t6_badclr", 5'd8, 32'h0000_0000);
    reset = 1'b0;
    tick();
    check_seq("t6_after", 3'b000, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
